// File: rtl/filtro_mano_pkg.sv
// filtro_mano_pkg: shared constants and FSM encoding for the hand-position filter
package filtro_mano_pkg;
  localparam int ANCHO_PANTALLA = 640;
  localparam int ANCHO_CANASTA = 64;
  localparam int MAX_PASO = 8;
  localparam int TIMEOUT_FRAMES = 30;
  localparam logic [7:0] BYTE_INVALIDO = 8'hFF;
  localparam logic [9:0] POS_MAX = 10'(ANCHO_PANTALLA - ANCHO_CANASTA);
  localparam logic [9:0] POS_CENTRO = 10'((ANCHO_PANTALLA - ANCHO_CANASTA) / 2);
  typedef enum logic [1:0] {SIN_DATOS = 2'd0, SIGUIENDO = 2'd1, PERDIDO = 2'd2} estado_t;
endpackage

// File: rtl/promedio_ventana_4.sv
// promedio_ventana_4: 4-sample sliding window with registered truncating mean
module promedio_ventana_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic       preload_en,
  input  logic [9:0] muestra,
  output logic [9:0] avg
);
  logic [3:0][9:0] win_q, win_d;
  logic [9:0] avg_q, avg_d;
  logic [11:0] sum;
  // preload fills the whole window so a fresh track starts at the new sample
  always_comb begin
    win_d = preload_en ? {4{muestra}} : shift_en ? {win_q[2:0], muestra} : win_q;
    sum = 12'(win_q[0]) + 12'(win_q[1]) + 12'(win_q[2]) + 12'(win_q[3]);
    avg_d = 10'(sum >> 2);
  end
  // window and mean registers; the mean lags the window by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      avg_q <= '0;
    end else begin
      win_q <= win_d;
      avg_q <= avg_d;
    end
  end
  assign avg = avg_q;
endmodule

// File: rtl/filtro_posicion_mano.sv
// filtro_posicion_mano: turns raw UART hand bytes into a slew-limited, frame-synchronous basket X
module filtro_posicion_mano
  import filtro_mano_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       frame_tick,
  output logic [9:0] pos_x_mano,
  output logic       pos_valid,
  output logic       sensor_lost
);
  localparam logic signed [10:0] PASO = 11'(MAX_PASO);
  localparam logic [4:0] TIMEOUT = 5'(TIMEOUT_FRAMES);
  estado_t state_q, state_d;
  logic [9:0] pos_q, pos_d, raw, avg, target, paso_pos;
  logic [4:0] cnt_q, cnt_d;
  logic signed [10:0] diff;
  logic valid, pos_valid_q, sensor_lost_q;
  promedio_ventana_4 u_prom (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (valid && state_q == SIGUIENDO),
    .preload_en(valid && state_q != SIGUIENDO),
    .muestra   (raw),
    .avg       (avg)
  );
  // sample mapping, clamped slew toward the average, saturating timeout and next state
  always_comb begin
    valid = received && rx_byte != BYTE_INVALIDO;
    raw = {1'b0, rx_byte, 1'b0} + {3'b0, rx_byte[7:1]};
    target = avg > POS_MAX ? POS_MAX : avg;
    diff = $signed({1'b0, target}) - $signed({1'b0, pos_q});
    paso_pos = diff > PASO ? pos_q + 10'(MAX_PASO) : diff < -PASO ? pos_q - 10'(MAX_PASO) : target;
    pos_d = frame_tick && state_q == SIGUIENDO ? paso_pos : pos_q;
    cnt_d = valid ? 5'd0 : frame_tick && cnt_q != TIMEOUT ? cnt_q + 5'd1 : cnt_q;
    state_d = valid ? SIGUIENDO : state_q == SIGUIENDO && cnt_d == TIMEOUT ? PERDIDO : state_q;
  end
  // tracking FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SIN_DATOS;
      pos_q <= POS_CENTRO;
      cnt_q <= '0;
      pos_valid_q <= 1'b0;
      sensor_lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      cnt_q <= cnt_d;
      pos_valid_q <= state_d == SIGUIENDO;
      sensor_lost_q <= state_d == PERDIDO;
    end
  end
  assign pos_x_mano = pos_q;
  assign pos_valid = pos_valid_q;
  assign sensor_lost = sensor_lost_q;
endmodule
